ft245_fifo_ctrl: RTL and testbench
==================================

# ft245_fifo_ctrl

Clocked controller for the FTDI FT245 asynchronous parallel FIFO, turning its RXF#/RD#/TXE#/WR strobes into two valid/ack byte streams for the FPGA fabric. It sits between the ft245 pad wrapper and the host-side logic. The wrapper owns the eight bidirectional SB_IO pads: it feeds this block the pad input bits and drives the pads from `tx_data_245` under `tx_oe_245`. All FT245 timing is derived from the clock period, so the block retargets by parameter only.

## Interface
- `FT245_WIDTH`, 8: data bus width.
- `CLOCK_PERIOD_NS`, 10.0 (real): `clk` period; all strobe cycle counts derive from it.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `rx_data_245` in W: data from the pad input buffers.
- `rxf_245` in 1: RXF#, low = FT245 holds read data; asynchronous.
- `rx_245` out 1: RD#, active-low read strobe.
- `tx_data_245` out W: data toward the pad output buffers.
- `txe_245` in 1: TXE#, low = FT245 can accept a byte; asynchronous.
- `wr_245` out 1: WR, active-high; the FT245 latches on its falling edge.
- `tx_oe_245` out 1: pad output enable.
- `rx_data_si` out W: received byte.
- `rx_rdy_si` out 1: `rx_data_si` valid.
- `rx_ack_si` in 1: consumer has taken the byte.
- `tx_data_si` in W: byte to send.
- `tx_rdy_si` in 1: `tx_data_si` valid.
- `tx_ack_si` out 1: one-cycle pulse; byte captured.

## Operation
- `rxf_245` and `txe_245` each pass through a 2-flop synchronizer (reset value 1) before any use.
- Cycle counts: N(t) = ceil(t / `CLOCK_PERIOD_NS`), minimum 1, computed at elaboration.
- Strobe durations: RD pulse 60 ns, RD recovery 80 ns, WR setup 20 ns, WR pulse 50 ns, WR recovery 80 ns.
- FSM states:
  - `IDLE`
  - `RD_PULSE`, `RD_RECOVER`
  - `WR_SETUP`, `WR_PULSE`, `WR_RECOVER`
  - One down-counter is loaded on every state entry.
- Read eligibility: synchronized RXF# = 0 and `rx_rdy_si` = 0 (one-byte RX buffer; no read while a byte is unconsumed).
- Write eligibility: synchronized TXE# = 0 and `tx_rdy_si` = 1.
- Both eligible in `IDLE`: round-robin. The side not served last goes first; after reset RX goes first.
- Read sequence:
  - `IDLE` → `RD_PULSE`: `rx_245` = 0 for N(60).
  - On the last `RD_PULSE` cycle, latch `rx_data_245` into `rx_data_si` and set `rx_rdy_si`.
  - `RD_RECOVER`: `rx_245` = 1 for N(80), then return to `IDLE`.
- RX handshake: `rx_rdy_si` clears on the cycle after `rx_ack_si` is sampled high. `rx_ack_si` while `rx_rdy_si` = 0 is ignored.
- Write sequence:
  - On entry from `IDLE`, register `tx_data_si` into `tx_data_245` and pulse `tx_ack_si` for exactly one cycle.
  - `WR_SETUP` for N(20): `tx_oe_245` = 1, `wr_245` = 0.
  - `WR_PULSE` for N(50): `wr_245` = 1.
  - `WR_RECOVER` for N(80): `wr_245` = 0; `tx_oe_245` stays 1 for its first cycle (data hold), then drops to 0; then return to `IDLE`.
- `tx_oe_245` and `rx_245` = 0 are never asserted in the same cycle.
- `tx_data_245` holds its value outside writes.

## Timing
- Reset values:
  - `rx_245` = 1, `wr_245` = 0, `tx_oe_245` = 0, `tx_data_245` = 0.
  - `rx_data_si` = 0, `rx_rdy_si` = 0, `tx_ack_si` = 0.
  - FSM = `IDLE`; round-robin pointer = RX.
- Reset asserted mid-operation aborts the strobe immediately (asynchronous). An in-flight RX byte is lost. A TX byte already acked is dropped.
- At 10 ns: RD# low 6 cycles, recovery 8 cycles; WR setup 2, pulse 5, recovery 8 cycles.
- Latency: RXF# falling → RD# falling = 3 cycles (2 sync + 1 FSM). `tx_rdy_si` with TXE# low (already synchronized) → `tx_ack_si` = 1 cycle.
- RXF#/TXE# deasserting mid-transaction does not shorten it. The FSM re-evaluates only in `IDLE`.

## Structure
- Package `ft245_pkg`: FSM state enum and the five timing constants in ns.
- One sub-module `ft245_sync`: the 2-flop synchronizer, instantiated twice.
- Pads and tri-state stay in the parent wrapper.

## Test plan
- RX single: RXF# low, bus = 0xA5 → RD# low 6 cycles starting 3 cycles later; `rx_rdy_si` = 1 with `rx_data_si` = 0xA5; ack → `rx_rdy_si` = 0 next cycle.
- RX backpressure: RXF# held low, no ack → exactly one RD# pulse; after ack, second pulse ≥ 8 cycles after the first RD# rise.
- TX single: TXE# low, `tx_rdy_si` with 0x3C → `tx_ack_si` one cycle; `tx_oe_245` up; `wr_245` high 5 cycles after 2 setup cycles with `tx_data_245` = 0x3C; oe drops 1 cycle after WR falls.
- TX blocked: TXE# high, `tx_rdy_si` = 1 → no ack, no WR; TXE# low → write proceeds.
- Contention: RXF# and TXE# low, `tx_rdy_si` = 1 → order RX, TX, RX, TX; never oe with RD# low.
- Reset mid-WR_PULSE: `rst` = 0 → `wr_245` = 0 and `tx_oe_245` = 0 immediately; after release, FSM in `IDLE`.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared types and FT245 strobe timing for the FT245 FIFO controller.
// Durations are kept in ns and converted to clock cycles at elaboration.
package ft245_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_PULSE,
    RD_RECOVER,
    WR_SETUP,
    WR_PULSE,
    WR_RECOVER
  } state_t;

  localparam real RD_PULSE_NS   = 60.0;
  localparam real RD_RECOVER_NS = 80.0;
  localparam real WR_SETUP_NS   = 20.0;
  localparam real WR_PULSE_NS   = 50.0;
  localparam real WR_RECOVER_NS = 80.0;

  // ceil(t / period), never less than one cycle
  function automatic int ns_to_cycles(input real t_ns, input real period_ns);
    int n;
    n = $rtoi(t_ns / period_ns);
    if ((real'(n) * period_ns) < t_ns) n = n + 1;
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/ft245_sync.sv
// Two-flop synchronizer for the asynchronous FT245 status flags (RXF#, TXE#).
module ft245_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ft245_fifo_ctrl.sv
// FT245 asynchronous FIFO controller: turns RXF#/RD#/TXE#/WR into valid/ack
// byte streams. Pad strobes are registered from the next state so they never glitch.
module ft245_fifo_ctrl
  import ft245_pkg::*;
#(
  parameter int  FT245_WIDTH     = 8,
  parameter real CLOCK_PERIOD_NS = 10.0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FT245_WIDTH-1:0] rx_data_245,
  input  logic                   rxf_245,
  output logic                   rx_245,
  output logic [FT245_WIDTH-1:0] tx_data_245,
  input  logic                   txe_245,
  output logic                   wr_245,
  output logic                   tx_oe_245,
  output logic [FT245_WIDTH-1:0] rx_data_si,
  output logic                   rx_rdy_si,
  input  logic                   rx_ack_si,
  input  logic [FT245_WIDTH-1:0] tx_data_si,
  input  logic                   tx_rdy_si,
  output logic                   tx_ack_si
);

  localparam int N_RD_PULSE   = ns_to_cycles(RD_PULSE_NS,   CLOCK_PERIOD_NS);
  localparam int N_RD_RECOVER = ns_to_cycles(RD_RECOVER_NS, CLOCK_PERIOD_NS);
  localparam int N_WR_SETUP   = ns_to_cycles(WR_SETUP_NS,   CLOCK_PERIOD_NS);
  localparam int N_WR_PULSE   = ns_to_cycles(WR_PULSE_NS,   CLOCK_PERIOD_NS);
  localparam int N_WR_RECOVER = ns_to_cycles(WR_RECOVER_NS, CLOCK_PERIOD_NS);
  localparam int N_RD_MAX     = (N_RD_PULSE > N_RD_RECOVER) ? N_RD_PULSE : N_RD_RECOVER;
  localparam int N_WR_MAX0    = (N_WR_SETUP > N_WR_PULSE) ? N_WR_SETUP : N_WR_PULSE;
  localparam int N_WR_MAX     = (N_WR_MAX0 > N_WR_RECOVER) ? N_WR_MAX0 : N_WR_RECOVER;
  localparam int N_MAX        = (N_RD_MAX > N_WR_MAX) ? N_RD_MAX : N_WR_MAX;
  localparam int CNT_W        = $clog2(N_MAX + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             rx_first;
  logic             rxf_sync;
  logic             txe_sync;
  logic             rd_ok;
  logic             wr_ok;
  logic             take_rx;
  logic             take_tx;

  // Counter reload value: the state lasts (value + 1) cycles
  function automatic logic [CNT_W-1:0] entry_count(input state_t s);
    case (s)
      RD_PULSE:   entry_count = CNT_W'(N_RD_PULSE - 1);
      RD_RECOVER: entry_count = CNT_W'(N_RD_RECOVER - 1);
      WR_SETUP:   entry_count = CNT_W'(N_WR_SETUP - 1);
      WR_PULSE:   entry_count = CNT_W'(N_WR_PULSE - 1);
      WR_RECOVER: entry_count = CNT_W'(N_WR_RECOVER - 1);
      default:    entry_count = '0;
    endcase
  endfunction

  ft245_sync #(.RST_VAL(1'b1)) u_rxf_sync (.clk(clk), .rst(rst), .d(rxf_245), .q(rxf_sync));
  ft245_sync #(.RST_VAL(1'b1)) u_txe_sync (.clk(clk), .rst(rst), .d(txe_245), .q(txe_sync));

  // A read needs an empty one-byte RX buffer
  assign rd_ok = !rxf_sync && !rx_rdy_si;
  assign wr_ok = !txe_sync && tx_rdy_si;

  always_comb begin
    state_next = state;
    take_rx    = 1'b0;
    take_tx    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_ok && (!wr_ok || rx_first)) begin
          take_rx    = 1'b1;
          state_next = RD_PULSE;
        end else if (wr_ok) begin
          take_tx    = 1'b1;
          state_next = WR_SETUP;
        end
      end
      RD_PULSE:   if (cnt == '0) state_next = RD_RECOVER;
      RD_RECOVER: if (cnt == '0) state_next = IDLE;
      WR_SETUP:   if (cnt == '0) state_next = WR_PULSE;
      WR_PULSE:   if (cnt == '0) state_next = WR_RECOVER;
      WR_RECOVER: if (cnt == '0) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rx_first <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= entry_count(state_next);
      else if (cnt != '0)      cnt <= cnt - CNT_W'(1);
      if (take_rx)      rx_first <= 1'b0;
      else if (take_tx) rx_first <= 1'b1;
    end
  end

  // Output enable covers setup, pulse and the first recovery cycle (data hold)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_245      <= 1'b1;
      wr_245      <= 1'b0;
      tx_oe_245   <= 1'b0;
      tx_data_245 <= '0;
      tx_ack_si   <= 1'b0;
      rx_data_si  <= '0;
      rx_rdy_si   <= 1'b0;
    end else begin
      rx_245    <= (state_next != RD_PULSE);
      wr_245    <= (state_next == WR_PULSE);
      tx_oe_245 <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                   ((state_next == WR_RECOVER) && (state != WR_RECOVER));
      tx_ack_si <= take_tx;
      if (take_tx) tx_data_245 <= tx_data_si;
      if ((state == RD_PULSE) && (cnt == '0)) begin
        rx_data_si <= rx_data_245;
        rx_rdy_si  <= 1'b1;
      end else if (rx_ack_si && rx_rdy_si) begin
        rx_rdy_si <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ft245_fifo_ctrl.sv
// Directed bench for ft245_fifo_ctrl at a 10 ns clock. Inputs change and
// outputs are sampled on the falling edge.
module tb_ft245_fifo_ctrl;
  import ft245_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data_245 = 8'h00;
  logic       rxf_245 = 1'b1;
  logic       rx_245;
  logic [7:0] tx_data_245;
  logic       txe_245 = 1'b1;
  logic       wr_245;
  logic       tx_oe_245;
  logic [7:0] rx_data_si;
  logic       rx_rdy_si;
  logic       rx_ack_si = 1'b0;
  logic [7:0] tx_data_si = 8'h00;
  logic       tx_rdy_si = 1'b0;
  logic       tx_ack_si;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ft245_fifo_ctrl #(.FT245_WIDTH(8), .CLOCK_PERIOD_NS(10.0)) dut (
    .clk(clk), .rst(rst),
    .rx_data_245(rx_data_245), .rxf_245(rxf_245), .rx_245(rx_245),
    .tx_data_245(tx_data_245), .txe_245(txe_245), .wr_245(wr_245),
    .tx_oe_245(tx_oe_245),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
    .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bus();
    rxf_245 = 1'b1; txe_245 = 1'b1; tx_rdy_si = 1'b0;
    rx_ack_si = 1'b1;
    tick(1);
    rx_ack_si = 1'b0;
    tick(20);
  endtask

  task automatic test_reset();
    logic [20:0] got;
    rst = 1'b0;
    tick(2);
    got = {rx_245, wr_245, tx_oe_245, tx_ack_si, rx_rdy_si, rx_data_si, tx_data_245};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", got, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
    end
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_rx_single();
    int lat;
    int low;
    rx_data_245 = 8'hA5; rxf_245 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rx_245 === 1'b0) begin lat = i; break; end
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL rx_latency: got %0d want 3", lat); end
    low = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_245 !== 1'b0) break;
      low++;
    end
    checks++;
    if (low != 6) begin errors++; $display("FAIL rx_pulse_len: got %0d want 6", low); end
    checks++;
    if ({rx_rdy_si, rx_data_si} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL rx_capture: got %b/%h want 1/a5", rx_rdy_si, rx_data_si);
    end
    rxf_245 = 1'b1; rx_data_245 = 8'hFF;
    tick(1);
    checks++;
    if ({rx_rdy_si, rx_data_si} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL rx_hold: got %b/%h want 1/a5", rx_rdy_si, rx_data_si);
    end
    rx_ack_si = 1'b1;
    tick(1);
    rx_ack_si = 1'b0;
    checks++;
    if (rx_rdy_si !== 1'b0) begin errors++; $display("FAIL rx_ack_clear: got %b want 0", rx_rdy_si); end
    tick(12);
  endtask

  task automatic test_rx_backpressure();
    int cyc, falls, rises, caps, falls_at_40;
    int fall_cyc[4];
    int rise_cyc[4];
    logic [7:0] cap[4];
    logic prev_rd, prev_rdy, rdy_at_40;
    cyc = 0; falls = 0; rises = 0; caps = 0; falls_at_40 = 0; rdy_at_40 = 1'b0;
    prev_rd = 1'b1; prev_rdy = 1'b0;
    foreach (fall_cyc[k]) begin fall_cyc[k] = 0; rise_cyc[k] = 0; cap[k] = 8'h00; end
    rx_data_245 = 8'h11; rxf_245 = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      cyc++;
      if (prev_rd && !rx_245) begin
        if (falls < 4) fall_cyc[falls] = cyc;
        falls++;
      end
      if (!prev_rd && rx_245) begin
        if (rises < 4) rise_cyc[rises] = cyc;
        rises++;
        rx_data_245 = 8'(8'h11 * (rises + 1));
      end
      if (!prev_rdy && rx_rdy_si) begin
        if (caps < 4) cap[caps] = rx_data_si;
        caps++;
      end
      prev_rd = rx_245; prev_rdy = rx_rdy_si;
      if (cyc == 40) begin falls_at_40 = falls; rdy_at_40 = rx_rdy_si; end
      rx_ack_si = (cyc >= 40) && rx_rdy_si && !rx_ack_si;
      if (caps >= 3) break;
    end
    checks++;
    if (falls_at_40 != 1 || rdy_at_40 !== 1'b1) begin
      errors++; $display("FAIL rx_backpressure_one_pulse: got %0d pulses rdy %b want 1 pulse rdy 1", falls_at_40, rdy_at_40);
    end
    checks++;
    if (caps < 3) begin
      errors++; $display("FAIL rx_backpressure_timeout: got %0d bytes want 3", caps);
    end else begin
      checks++;
      if (fall_cyc[1] - rise_cyc[0] < 8) begin
        errors++; $display("FAIL rx_backpressure_gap1: got %0d want >=8", fall_cyc[1] - rise_cyc[0]);
      end
      checks++;
      if (fall_cyc[2] - rise_cyc[1] < 8 || fall_cyc[2] - rise_cyc[1] > 9) begin
        errors++; $display("FAIL rx_recovery_gap: got %0d want 8..9", fall_cyc[2] - rise_cyc[1]);
      end
      checks++;
      if ({cap[0], cap[1], cap[2]} !== {8'h11, 8'h22, 8'h33}) begin
        errors++; $display("FAIL rx_bytes: got %h %h %h want 11 22 33", cap[0], cap[1], cap[2]);
      end
    end
    tick(1);
    rx_ack_si = 1'b0; rxf_245 = 1'b1;
    tick(15);
  endtask

  task automatic test_tx_single();
    logic [19:0] ack_v, oe_v, wr_v;
    logic bad_data;
    ack_v = '0; oe_v = '0; wr_v = '0; bad_data = 1'b0;
    txe_245 = 1'b0;
    tick(3);
    tx_data_si = 8'h3C; tx_rdy_si = 1'b1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      ack_v[i] = tx_ack_si; oe_v[i] = tx_oe_245; wr_v[i] = wr_245;
      if (wr_245 && tx_data_245 !== 8'h3C) bad_data = 1'b1;
      if (tx_ack_si) begin tx_rdy_si = 1'b0; tx_data_si = 8'hEE; end
    end
    checks++;
    if (ack_v !== 20'h00002) begin errors++; $display("FAIL tx_ack_pulse: got %h want 00002", ack_v); end
    checks++;
    if (oe_v !== 20'h001FE) begin errors++; $display("FAIL tx_oe_window: got %h want 001fe", oe_v); end
    checks++;
    if (wr_v !== 20'h000F8) begin errors++; $display("FAIL tx_wr_window: got %h want 000f8", wr_v); end
    checks++;
    if (bad_data || tx_data_245 !== 8'h3C) begin
      errors++; $display("FAIL tx_data: got %h want 3c", tx_data_245);
    end
    idle_bus();
  endtask

  task automatic test_tx_blocked();
    logic any;
    int ack_at, wr_cnt;
    any = 1'b0; ack_at = 0; wr_cnt = 0;
    txe_245 = 1'b1;
    tick(3);
    tx_data_si = 8'h5A; tx_rdy_si = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_ack_si || wr_245 || tx_oe_245) any = 1'b1;
    end
    checks++;
    if (any !== 1'b0) begin errors++; $display("FAIL tx_blocked_activity: got %b want 0", any); end
    checks++;
    if (tx_data_245 !== 8'h3C) begin errors++; $display("FAIL tx_data_hold: got %h want 3c", tx_data_245); end
    txe_245 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tx_ack_si) begin ack_at = i; break; end
    end
    tx_rdy_si = 1'b0;
    checks++;
    if (ack_at != 3 || tx_data_245 !== 8'h5A) begin
      errors++; $display("FAIL tx_unblock: got ack at %0d data %h want 3 / 5a", ack_at, tx_data_245);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_245) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 5) begin errors++; $display("FAIL tx_unblock_wr: got %0d want 5", wr_cnt); end
    idle_bus();
  endtask

  task automatic test_contention();
    logic [3:0] ev;
    logic [7:0] wdat[2];
    int n, nw;
    logic prev_rd, prev_wr, clash;
    ev = '0; n = 0; nw = 0; prev_rd = 1'b1; prev_wr = 1'b0; clash = 1'b0;
    wdat[0] = 8'h00; wdat[1] = 8'h00;
    rx_data_245 = 8'h42; tx_data_si = 8'h81;
    rxf_245 = 1'b0; txe_245 = 1'b0; tx_rdy_si = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_oe_245 && !rx_245) clash = 1'b1;
      if (prev_rd && !rx_245) begin
        if (n < 4) ev[n] = 1'b0;
        n++;
      end
      if (!prev_wr && wr_245) begin
        if (n < 4) ev[n] = 1'b1;
        n++;
        if (nw < 2) wdat[nw] = tx_data_245;
        nw++;
      end
      prev_rd = rx_245; prev_wr = wr_245;
      if (tx_ack_si) tx_data_si = 8'h82;
      rx_ack_si = rx_rdy_si && !rx_ack_si;
      if (n >= 4) break;
    end
    checks++;
    if (n < 4 || ev !== 4'b1010) begin
      errors++; $display("FAIL contention_order: got %0d events %b want 4 events 1010", n, ev);
    end
    checks++;
    if (clash !== 1'b0) begin errors++; $display("FAIL contention_oe_rd: got %b want 0", clash); end
    checks++;
    if ({wdat[0], wdat[1]} !== {8'h81, 8'h82}) begin
      errors++; $display("FAIL contention_data: got %h %h want 81 82", wdat[0], wdat[1]);
    end
    tick(1);
    rx_ack_si = 1'b0;
    idle_bus();
  endtask

  task automatic test_reset_mid_write();
    int wr_at, rd_at;
    logic ack_seen;
    wr_at = 0; rd_at = 0; ack_seen = 1'b0;
    txe_245 = 1'b0; tx_data_si = 8'h99; tx_rdy_si = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tx_ack_si) tx_rdy_si = 1'b0;
      if (wr_245) begin wr_at = i; break; end
    end
    checks++;
    if (wr_at == 0) begin errors++; $display("FAIL rstwr_no_pulse: got no WR want WR high"); end
    tick(2);
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_245, tx_oe_245, rx_245, tx_ack_si, tx_data_245} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rstwr_abort: got wr %b oe %b rd %b ack %b data %h want 0 0 1 0 00",
                         wr_245, tx_oe_245, rx_245, tx_ack_si, tx_data_245);
    end
    tx_rdy_si = 1'b0; txe_245 = 1'b1; rxf_245 = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    checks++;
    if (dut.state !== IDLE || wr_245 !== 1'b0 || tx_oe_245 !== 1'b0) begin
      errors++; $display("FAIL rstwr_idle: got state %0d wr %b oe %b want %0d 0 0", dut.state, wr_245, tx_oe_245, IDLE);
    end
    rx_data_245 = 8'h5E; rxf_245 = 1'b0; txe_245 = 1'b0; tx_data_si = 8'h77; tx_rdy_si = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tx_ack_si) ack_seen = 1'b1;
      if (rx_245 === 1'b0) begin rd_at = i; break; end
    end
    checks++;
    if (rd_at != 3 || ack_seen !== 1'b0) begin
      errors++; $display("FAIL rstwr_rx_first: got rd at %0d ack %b want 3 0", rd_at, ack_seen);
    end
    tx_rdy_si = 1'b0; rxf_245 = 1'b1;
    tick(20);
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_rx_backpressure();
    test_tx_single();
    test_tx_blocked();
    test_contention();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
